// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types: response codes, write/read FSM states and
// 32-bit default address/data types used by the AXI4-Lite slaves.
package axi_lite_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage

// File: rtl/axi_lite_strb_merge.sv
// Byte-lane merge: each byte of o_data comes from i_new where the
// strobe bit is set, else from i_old.
// Ports: i_old, i_new (DATA_W), i_strb (DATA_W/8) -> o_data (DATA_W).
module axi_lite_strb_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   i_old,
    input  logic [DATA_W-1:0]   i_new,
    input  logic [DATA_W/8-1:0] i_strb,
    output logic [DATA_W-1:0]   o_data
);

    always_comb begin
        o_data = i_old;
        for (int i = 0; i < DATA_W/8; i++) begin
            if (i_strb[i]) begin
                o_data[i*8 +: 8] = i_new[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file with byte strobes, decoupled AW/W and
// independent read/write FSMs. Register array is named `buffer`.
// Ports: aclk, areset_n (async active-low), AW/W/B and AR/R channels.
// Macro AXI_LITE_REGFILE_ERR_EN: out-of-range accesses answer SLVERR;
// when undefined they answer OKAY (writes dropped, reads return 0).
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                aclk,
    input  logic                areset_n,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready
);

    localparam int BYTES = DATA_W / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int HI    = LSB + IDX_W;

    // Any set bit at or above HI means addr >= NUM_REGS*BYTES.
    function automatic logic f_oor(input logic [ADDR_W-1:0] a);
        return |(a >> HI);
    endfunction

    logic [DATA_W-1:0] buffer [NUM_REGS];

    w_state_t r_wstate;
    w_state_t w_wstate_nxt;
    r_state_t r_rstate;
    r_state_t w_rstate_nxt;

    // Keeps the ready outputs low until the first edge after reset.
    logic r_alive;

    logic              r_aw_held;
    logic              r_w_held;
    logic [ADDR_W-1:0] r_awaddr;
    logic [DATA_W-1:0] r_wdata;
    logic [BYTES-1:0]  r_wstrb;
    logic [DATA_W-1:0] r_rdata;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_ar_hs;
    logic              w_commit;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wd;
    logic [BYTES-1:0]  w_ws;
    logic [IDX_W-1:0]  w_widx;
    logic              w_woor;
    logic [DATA_W-1:0] w_merged;
    logic [IDX_W-1:0]  w_ridx;
    logic              w_roor;
    logic              w_unused_addr;

    assign w_aw_hs = awvalid && awready;
    assign w_w_hs  = wvalid && wready;
    assign w_ar_hs = arvalid && arready;

    // Commit on the edge completing the later of AW and W.
    assign w_commit = (r_wstate == W_IDLE)
                    && (w_aw_hs || r_aw_held)
                    && (w_w_hs || r_w_held);

    assign w_waddr = w_aw_hs ? awaddr : r_awaddr;
    assign w_wd    = w_w_hs ? wdata : r_wdata;
    assign w_ws    = w_w_hs ? wstrb : r_wstrb;
    assign w_widx  = w_waddr[LSB +: IDX_W];
    assign w_woor  = f_oor(w_waddr);

    assign w_ridx = araddr[LSB +: IDX_W];
    assign w_roor = f_oor(araddr);

    // Sub-word address bits are ignored: accesses are silently aligned.
    assign w_unused_addr = ^{w_waddr[LSB-1:0], araddr[LSB-1:0]};

    axi_lite_strb_merge #(
        .DATA_W (DATA_W)
    ) u_merge (
        .i_old  (buffer[w_widx]),
        .i_new  (w_wd),
        .i_strb (w_ws),
        .o_data (w_merged)
    );

    // State registers
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_wstate_nxt = r_wstate;
        unique case (r_wstate)
            W_IDLE: if (w_commit) w_wstate_nxt = W_RESP;
            W_RESP: if (bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        unique case (r_rstate)
            R_IDLE: if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA: if (rready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Outputs derived from state only
    always_comb begin
        awready = 1'b0;
        wready  = 1'b0;
        arready = 1'b0;
        bvalid  = (r_wstate == W_RESP);
        rvalid  = (r_rstate == R_DATA);
        if (r_alive && r_wstate == W_IDLE) begin
            awready = !r_aw_held;
            wready  = !r_w_held;
        end
        if (r_alive && r_rstate == R_IDLE) begin
            arready = 1'b1;
        end
    end

    // Held flags and latched write payload
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_alive   <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_alive <= 1'b1;
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awaddr  <= awaddr;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= wdata;
                    r_wstrb  <= wstrb;
                end
            end
        end
    end

    // Register array
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                buffer[i] <= '0;
            end
        end else if (w_commit && !w_woor) begin
            buffer[w_widx] <= w_merged;
        end
    end

    // Read data: captured before any same-edge write lands
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_rdata <= '0;
        end else if (w_ar_hs) begin
            r_rdata <= w_roor ? '0 : buffer[w_ridx];
        end else if (rvalid && rready) begin
            r_rdata <= '0;
        end
    end

    assign rdata = r_rdata;

`ifdef AXI_LITE_REGFILE_ERR_EN
    resp_t r_bresp;
    resp_t r_rresp;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_bresp <= OKAY;
            r_rresp <= OKAY;
        end else begin
            if (w_commit) begin
                r_bresp <= w_woor ? SLVERR : OKAY;
            end
            if (w_ar_hs) begin
                r_rresp <= w_roor ? SLVERR : OKAY;
            end
        end
    end

    assign bresp = r_bresp;
    assign rresp = r_rresp;
`else
    assign bresp = OKAY;
    assign rresp = OKAY;
`endif

endmodule
